cache_data_array_p: RTL and testbench
=====================================

Name: cache_data_array_p

Overview:
- Parametrised successor to the one-hot cache data array.
- Binary-indexed, flop-based storage of NUM_BLOCKS lines × WORDS words × DATA_W bits.
- CPU port: registered read (1-cycle latency) and byte-masked writes.
- Built-in line-fill engine loads a whole block from the memory side, one word per accepted beat. Sits between the cache controller (tag/FSM) and the memory interface.

Parameters:
- NUM_BLOCKS, 128, number of cache lines; power of two, ≥2.
- WORDS, 8, words per line; power of two, ≥2.
- DATA_W, 16, bits per word; multiple of 8.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-low; takes effect on the clk edge while low.
- rd_en  in  1  CPU read request.
- wr_en  in  1  CPU write request.
- index  in  IDX_W  CPU line index; IDX_W = clog2(NUM_BLOCKS).
- word  in  OFF_W  CPU word offset within line; OFF_W = clog2(WORDS).
- wr_data  in  DATA_W  CPU write data.
- byte_en  in  DATA_W/8  per-byte write mask; bit i covers wr_data[8i+7:8i].
- rd_data  out  DATA_W  registered read data.
- rd_valid  out  1  rd_data updated this cycle from an accepted read.
- busy  out  1  fill in progress; CPU accesses are ignored.
- fill_start  in  1  begin line fill of fill_index.
- fill_index  in  IDX_W  line to fill; sampled with fill_start.
- fill_valid  in  1  fill_data beat valid; accepted only while busy.
- fill_data  in  DATA_W  fill word; beats arrive in order, word 0 first.
- fill_done  out  1  one-cycle pulse after the last fill word is written.

Behaviour:
- Reset (rst low at an edge):
  - all storage cleared to 0; rd_data=0, rd_valid=0, busy=0, fill_done=0.
  - FSM to IDLE, beat counter to 0.
  - Aborts any fill in progress; partially filled line is cleared with the rest.
- CPU write:
  - Accepted when wr_en=1 and busy=0.
  - Bytes of [index][word] with byte_en=1 take wr_data on the edge; other bytes hold.
  - byte_en=0 means no change.
- CPU read:
  - Accepted when rd_en=1, wr_en=0 and busy=0.
  - Next cycle: rd_data = stored [index][word], rd_valid=1.
  - Otherwise rd_valid=0 and rd_data holds its previous value.
- rd_en and wr_en both high: write performed, read dropped, rd_valid=0 next cycle.
- Read the cycle after a write to the same word returns the new data. No same-cycle bypass: the array is read before the edge.
- FSM IDLE:
  - fill_start=1: latch fill_index, counter=0, go to FILL; busy=1 from the next cycle.
  - A CPU access presented in the same cycle as fill_start is still performed.
- FSM FILL:
  - busy=1.
  - Each fill_valid=1 writes fill_data to [latched][counter], all bytes, and increments the counter.
  - fill_valid=0 stalls with no timeout.
  - fill_start is ignored.
  - When the beat with counter=WORDS-1 is accepted: go to IDLE.
  - In the following cycle busy=0 and fill_done=1 for exactly one cycle; the counter wraps to 0.
- fill_valid in IDLE is ignored.
- A CPU access during busy is dropped entirely: no write, rd_valid=0.
- Index and word ranges are exact powers of two, so no out-of-range case exists.

Optional Feature:
- Macro: CACHE_DATA_ARRAY_P_PARITY_EN.
- Defined:
  - One even-parity bit is stored per word and recomputed on every write, CPU or fill. A partial byte write recomputes over the merged word.
  - Added output parity_err (1 bit), asserted with rd_valid when the stored parity mismatches; reset 0.
- Undefined: no parity storage and no parity_err port.

Decomposition:
- Package cache_da_pkg:
  - IDX_W/OFF_W derivation functions (clog2).
  - FSM state enum {IDLE, FILL}.
  - Byte-merge function (old word, new word, byte_en → merged).
- One sub-module, cache_da_fill_ctrl:
  - Holds FSM, beat counter, latched index, busy and fill_done.
  - Outputs the fill write strobe and address to the array core.

Test Plan:
- Reset, then read [5][3] → rd_valid=1 one cycle later, rd_data=0x0000.
- Write [5][3]=0xABCD, byte_en=2'b11; then write 0x12FF with byte_en=2'b01; read [5][3] → 0xABFF.
- fill_start index=9; beats 0x1000..0x1007 with a 2-cycle gap after beat 3:
  - busy high throughout; fill_done pulses the cycle after beat 7.
  - Reads of [9][0..7] → 0x1000..0x1007.
- During a fill: wr_en to [9][0]=0xDEAD and rd_en → both ignored, rd_valid=0; [9][0] ends as 0x1000.
- rst low after 4 fill beats:
  - busy=0 next cycle, no fill_done.
  - [9][0] reads 0.
  - A new fill_start is accepted.
- PARITY_EN: force-flip a stored bit of [2][1] via hierarchical poke; read → parity_err=1 with rd_valid. A clean word → parity_err=0.

Source files
------------

// File: rtl/cache_da_pkg.sv
// cache_da_pkg: shared widths, fill FSM states and the byte-merge helper for cache_data_array_p
package cache_da_pkg;
  localparam int MAX_W = 64;
  localparam int MAX_BE = MAX_W / 8;
  typedef enum logic {IDLE, FILL} fill_state_t;
  function automatic int idx_w(input int num_blocks);
    return $clog2(num_blocks);
  endfunction
  function automatic int off_w(input int words);
    return $clog2(words);
  endfunction
  function automatic logic [MAX_W-1:0] byte_merge(
    input logic [MAX_W-1:0] old_w,
    input logic [MAX_W-1:0] new_w,
    input logic [MAX_BE-1:0] be
  );
    logic [MAX_W-1:0] m;
    for (int i = 0; i < MAX_BE; i++) m[8*i+:8] = be[i] ? new_w[8*i+:8] : old_w[8*i+:8];
    return m;
  endfunction
endpackage

// File: rtl/cache_da_fill_ctrl.sv
// cache_da_fill_ctrl: line-fill FSM producing one array write per accepted beat
module cache_da_fill_ctrl
  import cache_da_pkg::*;
#(
  parameter int IDX_W = 7,
  parameter int OFF_W = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   fill_start,
  input  logic [IDX_W-1:0]       fill_index,
  input  logic                   fill_valid,
  output logic                   busy,
  output logic                   fill_done,
  output logic                   fill_we,
  output logic [IDX_W+OFF_W-1:0] fill_addr
);
  fill_state_t state;
  logic [OFF_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  assign fill_we = (state == FILL) && fill_valid;
  assign fill_addr = {idx, cnt};
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      busy <= 1'b0;
      fill_done <= 1'b0;
    end else begin
      fill_done <= 1'b0;
      if (state == IDLE) begin
        if (fill_start) begin
          state <= FILL;
          idx <= fill_index;
          cnt <= '0;
          busy <= 1'b1;
        end
      end else if (fill_valid) begin
        // counter wraps to 0 naturally on the last beat
        cnt <= cnt + 1'b1;
        if (&cnt) begin
          state <= IDLE;
          busy <= 1'b0;
          fill_done <= 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/cache_data_array_p.sv
// cache_data_array_p: flop-based cache data array with CPU port and line-fill engine; parity via CACHE_DATA_ARRAY_P_PARITY_EN
module cache_data_array_p
  import cache_da_pkg::*;
#(
  parameter int NUM_BLOCKS = 128,
  parameter int WORDS = 8,
  parameter int DATA_W = 16,
  localparam int IDX_W = idx_w(NUM_BLOCKS),
  localparam int OFF_W = off_w(WORDS),
  localparam int BE_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  index,
  input  logic [OFF_W-1:0]  word,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [BE_W-1:0]   byte_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy,
  input  logic              fill_start,
  input  logic [IDX_W-1:0]  fill_index,
  input  logic              fill_valid,
  input  logic [DATA_W-1:0] fill_data,
  output logic              fill_done
`ifdef CACHE_DATA_ARRAY_P_PARITY_EN
  ,
  output logic              parity_err
`endif
);
  localparam int DEPTH = NUM_BLOCKS * WORDS;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [IDX_W+OFF_W-1:0] a, fill_addr;
  logic [DATA_W-1:0] wr_word;
  logic fill_we, rd_acc, wr_acc;
  assign a = {index, word};
  assign wr_acc = wr_en && !busy;
  assign rd_acc = rd_en && !wr_en && !busy;
  assign wr_word = DATA_W'(byte_merge(MAX_W'(mem[a]), MAX_W'(wr_data), MAX_BE'(byte_en)));
  cache_da_fill_ctrl #(.IDX_W(IDX_W), .OFF_W(OFF_W)) u_fill (
    .clk(clk),
    .rst(rst),
    .fill_start(fill_start),
    .fill_index(fill_index),
    .fill_valid(fill_valid),
    .busy(busy),
    .fill_done(fill_done),
    .fill_we(fill_we),
    .fill_addr(fill_addr)
  );
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem <= '{default: '0};
      rd_data <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_acc;
      if (rd_acc) rd_data <= mem[a];
      if (wr_acc) mem[a] <= wr_word;
      if (fill_we) mem[fill_addr] <= fill_data;
    end
  end
`ifdef CACHE_DATA_ARRAY_P_PARITY_EN
  logic par [DEPTH];
  always_ff @(posedge clk) begin
    if (!rst) begin
      par <= '{default: 1'b0};
      parity_err <= 1'b0;
    end else begin
      parity_err <= rd_acc && ((^mem[a]) != par[a]);
      if (wr_acc) par[a] <= ^wr_word;
      if (fill_we) par[fill_addr] <= ^fill_data;
    end
  end
`endif
endmodule

// File: tb/tb_cache_data_array_p.sv
// tb_cache_data_array_p: directed stimulus checked every cycle against an array-level reference model
module tb_cache_data_array_p;
  localparam int NB = 128, W = 8, DW = 16, IW = 7, OW = 3, BW = 2;
  logic clk = 1'b0, rst = 1'b0, rd_en = 1'b0, wr_en = 1'b0, fill_start = 1'b0, fill_valid = 1'b0;
  logic [IW-1:0] index = '0, fill_index = '0;
  logic [OW-1:0] word = '0;
  logic [DW-1:0] wr_data = '0, fill_data = '0;
  logic [BW-1:0] byte_en = '0;
  logic [DW-1:0] rd_data;
  logic rd_valid, busy, fill_done;
`ifdef CACHE_DATA_ARRAY_P_PARITY_EN
  logic parity_err;
`endif
  int nvec = 0, nerr = 0;
  bit chk = 1'b0;
  always #5 clk = ~clk;
  cache_data_array_p dut (
    .clk(clk),
    .rst(rst),
    .rd_en(rd_en),
    .wr_en(wr_en),
    .index(index),
    .word(word),
    .wr_data(wr_data),
    .byte_en(byte_en),
    .rd_data(rd_data),
    .rd_valid(rd_valid),
    .busy(busy),
    .fill_start(fill_start),
    .fill_index(fill_index),
    .fill_valid(fill_valid),
    .fill_data(fill_data),
    .fill_done(fill_done)
`ifdef CACHE_DATA_ARRAY_P_PARITY_EN
    ,
    .parity_err(parity_err)
`endif
  );
  logic [DW-1:0] m_mem [NB*W];
  bit m_par [NB*W];
  logic [DW-1:0] e_rd = '0;
  bit e_rv = 1'b0, e_busy = 1'b0, e_done = 1'b0, e_pe = 1'b0;
  int m_idx = 0, m_cnt = 0;
  // reference: storage as a plain array, fill as "next beat goes to line*W+count"
  always @(posedge clk) begin
    int ad;
    logic [DW-1:0] nw;
    ad = int'(index) * W + int'(word);
    e_done = 1'b0;
    e_rv = 1'b0;
    e_pe = 1'b0;
    if (!rst) begin
      foreach (m_mem[i]) begin
        m_mem[i] = '0;
        m_par[i] = 1'b0;
      end
      e_rd = '0;
      e_busy = 1'b0;
      m_cnt = 0;
    end else if (!e_busy) begin
      if (wr_en) begin
        nw = m_mem[ad];
        for (int b = 0; b < BW; b++) if (byte_en[b]) nw[8*b+:8] = wr_data[8*b+:8];
        m_mem[ad] = nw;
        m_par[ad] = ^nw;
      end else if (rd_en) begin
        e_rv = 1'b1;
        e_rd = m_mem[ad];
        e_pe = (^m_mem[ad]) != m_par[ad];
      end
      if (fill_start) begin
        e_busy = 1'b1;
        m_idx = int'(fill_index);
        m_cnt = 0;
      end
    end else if (fill_valid) begin
      m_mem[m_idx*W+m_cnt] = fill_data;
      m_par[m_idx*W+m_cnt] = ^fill_data;
      if (m_cnt == W - 1) begin
        e_busy = 1'b0;
        e_done = 1'b1;
        m_cnt = 0;
      end else m_cnt++;
    end
  end
  task automatic cmp(input string n, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h at %0t", n, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    if (chk) begin
      cmp("model rd_valid", DW'(rd_valid), DW'(e_rv));
      cmp("model rd_data", rd_data, e_rd);
      cmp("model busy", DW'(busy), DW'(e_busy));
      cmp("model fill_done", DW'(fill_done), DW'(e_done));
`ifdef CACHE_DATA_ARRAY_P_PARITY_EN
      cmp("model parity_err", DW'(parity_err), DW'(e_pe));
`endif
    end
  end
  task automatic step();
    @(negedge clk);
  endtask
  task automatic idle();
    rd_en = 1'b0;
    wr_en = 1'b0;
    fill_start = 1'b0;
    fill_valid = 1'b0;
    byte_en = '0;
  endtask
  task automatic cpu_wr(input int i, input int w, input logic [DW-1:0] d, input logic [BW-1:0] be);
    index = IW'(i);
    word = OW'(w);
    wr_data = d;
    byte_en = be;
    wr_en = 1'b1;
    step();
    idle();
  endtask
  task automatic cpu_rd(input int i, input int w, input logic [DW-1:0] exp, input string n);
    index = IW'(i);
    word = OW'(w);
    rd_en = 1'b1;
    step();
    cmp({n, " valid"}, DW'(rd_valid), 16'd1);
    cmp(n, rd_data, exp);
    idle();
  endtask
  initial begin
    step();
    step();
    chk = 1'b1;
    rst = 1'b1;
    cmp("reset busy", DW'(busy), 16'd0);
    cmp("reset rd_valid", DW'(rd_valid), 16'd0);
    cmp("reset rd_data", rd_data, 16'h0000);
    cpu_rd(5, 3, 16'h0000, "read after reset");
    cpu_wr(5, 3, 16'hABCD, 2'b11);
    cpu_wr(5, 3, 16'h12FF, 2'b01);
    cpu_rd(5, 3, 16'hABFF, "byte merge");
    cpu_wr(5, 3, 16'hFFFF, 2'b00);
    cpu_rd(5, 3, 16'hABFF, "zero byte_en");
    cpu_wr(1, 2, 16'h00AA, 2'b11);
    index = 7'd1;
    word = 3'd2;
    wr_data = 16'h5555;
    byte_en = 2'b11;
    wr_en = 1'b1;
    rd_en = 1'b1;
    step();
    cmp("rd+wr drops read", DW'(rd_valid), 16'd0);
    idle();
    cpu_rd(1, 2, 16'h5555, "rd+wr write wins");
    fill_valid = 1'b1;
    fill_data = 16'hBEEF;
    step();
    idle();
    cpu_rd(0, 0, 16'h0000, "idle fill_valid ignored");
    fill_index = 7'd9;
    fill_start = 1'b1;
    index = 7'd4;
    word = 3'd4;
    wr_data = 16'h7777;
    byte_en = 2'b11;
    wr_en = 1'b1;
    step();
    idle();
    cmp("busy after start", DW'(busy), 16'd1);
    for (int k = 0; k < 8; k++) begin
      fill_valid = 1'b1;
      fill_data = 16'h1000 + 16'(k);
      step();
      fill_valid = 1'b0;
      cmp("busy during fill", DW'(busy), k < 7 ? 16'd1 : 16'd0);
      cmp("fill_done timing", DW'(fill_done), k < 7 ? 16'd0 : 16'd1);
      if (k == 3) begin
        index = 7'd9;
        word = 3'd0;
        wr_data = 16'hDEAD;
        byte_en = 2'b11;
        wr_en = 1'b1;
        fill_start = 1'b1;
        fill_index = 7'd20;
        step();
        idle();
        cmp("gap busy", DW'(busy), 16'd1);
        index = 7'd9;
        rd_en = 1'b1;
        step();
        idle();
        cmp("read while busy", DW'(rd_valid), 16'd0);
      end
    end
    step();
    cmp("fill_done one cycle", DW'(fill_done), 16'd0);
    for (int k = 0; k < 8; k++) cpu_rd(9, k, 16'h1000 + 16'(k), "filled word");
    cpu_rd(4, 4, 16'h7777, "write with fill_start");
    fill_index = 7'd9;
    fill_start = 1'b1;
    step();
    idle();
    for (int k = 0; k < 4; k++) begin
      fill_valid = 1'b1;
      fill_data = 16'h2000 + 16'(k);
      step();
    end
    idle();
    rst = 1'b0;
    step();
    rst = 1'b1;
    cmp("abort busy", DW'(busy), 16'd0);
    cmp("abort no done", DW'(fill_done), 16'd0);
    step();
    cmp("abort no late done", DW'(fill_done), 16'd0);
    cpu_rd(9, 0, 16'h0000, "aborted line cleared");
    cpu_rd(4, 4, 16'h0000, "reset clears array");
    fill_index = 7'd3;
    fill_start = 1'b1;
    step();
    idle();
    cmp("refill busy", DW'(busy), 16'd1);
    for (int k = 0; k < 8; k++) begin
      fill_valid = 1'b1;
      fill_data = 16'h3000 + 16'(k);
      step();
    end
    idle();
    cmp("refill done", DW'(fill_done), 16'd1);
    cpu_rd(3, 7, 16'h3007, "refill last word");
    cpu_rd(3, 0, 16'h3000, "refill first word");
`ifdef CACHE_DATA_ARRAY_P_PARITY_EN
    cpu_wr(2, 1, 16'h0F0F, 2'b11);
    dut.mem[2*W+1][0] = ~dut.mem[2*W+1][0];
    m_mem[2*W+1][0] = ~m_mem[2*W+1][0];
    cpu_rd(2, 1, 16'h0F0E, "poked word");
    cmp("parity_err poked", DW'(parity_err), 16'd1);
    cpu_rd(2, 0, 16'h0000, "clean word");
    cmp("parity_err clean", DW'(parity_err), 16'd0);
`endif
    step();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
